// File: rtl/rv_axi4_lite_req_arbiter_pkg.sv
// Shared AXI4-lite types and arbiter FSM states for rv_axi4_lite_req_arbiter.
package rv_axi4_lite_req_arbiter_pkg;

   typedef logic [1:0] resp_t;
   typedef logic [2:0] prot_t;

   localparam resp_t RESP_OKAY    = 2'b00;
   localparam resp_t RESP_SLVERR  = 2'b10;
   localparam resp_t RESP_DECERR  = 2'b11;
   localparam prot_t PROT_DEFAULT = 3'b000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ADDR   = 2'd1,
      ST_RESP   = 2'd2,
      ST_RETURN = 2'd3
   } arb_state_t;

   function automatic logic resp_is_err(input resp_t resp);
      return (resp != RESP_OKAY);
   endfunction

endpackage

// File: rtl/rv_axi4_lite_req_arbiter_if.sv
// AXI4-lite manager/subordinate bundle used by rv_axi4_lite_req_arbiter.
interface rv_axi4_lite_req_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) ();
   import rv_axi4_lite_req_arbiter_pkg::*;

   logic                    awvalid;
   logic                    awready;
   logic [ADDR_WIDTH-1:0]   awaddr;
   prot_t                   awprot;
   logic                    wvalid;
   logic                    wready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    bvalid;
   logic                    bready;
   resp_t                   bresp;
   logic                    arvalid;
   logic                    arready;
   logic [ADDR_WIDTH-1:0]   araddr;
   prot_t                   arprot;
   logic                    rvalid;
   logic                    rready;
   logic [DATA_WIDTH-1:0]   rdata;
   resp_t                   rresp;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

endinterface

// File: rtl/rv_axi4_lite_req_arbiter_rr.sv
// Combinational round-robin picker: first request after ptr, with wrap-around.
module rv_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               found
);

   logic [IDX_W-1:0] cand_s;

   // Scan ptr+1 .. ptr+NUM_REQ and keep the first hit
   always_comb begin
      grant     = {NUM_REQ{1'b0}};
      grant_idx = {IDX_W{1'b0}};
      found     = 1'b0;
      cand_s    = {IDX_W{1'b0}};
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_s = IDX_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && req[cand_s]) begin
            grant[cand_s] = 1'b1;
            grant_idx     = cand_s;
            found         = 1'b1;
         end else begin
            grant_idx = grant_idx;
         end
      end
   end

endmodule

// File: rtl/rv_axi4_lite_req_arbiter.sv
// Round-robin sharing of one AXI4-lite manager port between NUM_REQ requesters.
// Define RV_AXI_ARB_LOCK_EN to let a requester keep the grant across commands via req_lock.
module rv_axi4_lite_req_arbiter
   import rv_axi4_lite_req_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_lock,
   output logic [NUM_REQ-1:0]            rsp_valid,
   input  logic [NUM_REQ-1:0]            rsp_ready,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic                          rsp_err,
   rv_axi4_lite_req_arbiter_if.master    m
);
   localparam int IDX_W = $clog2(NUM_REQ);

   arb_state_t            state_r, state_nxt_s;
   logic [IDX_W-1:0]      ptr_r, gnt_idx_r, grant_idx_s;
   logic [NUM_REQ-1:0]    grant_s, req_mask_s, gnt_onehot_s, rsp_valid_r;
   logic                  found_s, capture_s, addr_done_s, resp_fire_s, ret_fire_s;
   logic                  write_r, awvalid_r, wvalid_r, arvalid_r, bready_r, rready_r, rsp_err_r;
   logic [ADDR_WIDTH-1:0] addr_r, sel_addr_s;
   logic [DATA_WIDTH-1:0] data_r, sel_data_s, rsp_data_r;

   assign gnt_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx_r;

`ifdef RV_AXI_ARB_LOCK_EN
   logic lock_r, lock_cmd_r;
   assign req_mask_s = lock_r ? (req_valid & gnt_onehot_s) : req_valid;

   // Lock state takes effect once the command carrying it has been returned
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lock_r     <= 1'b0;
         lock_cmd_r <= 1'b0;
      end else begin
         if (capture_s) lock_cmd_r <= |(req_lock & grant_s);
         if ((state_r == ST_RETURN) && ret_fire_s) lock_r <= lock_cmd_r;
      end
   end
`else
   logic unused_lock_s;
   assign unused_lock_s = ^req_lock;
   assign req_mask_s    = req_valid;
`endif

   rv_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .req       (req_mask_s),
      .ptr       (ptr_r),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .found     (found_s)
   );

   // Payload mux of the granted requester
   always_comb begin
      sel_addr_s = {ADDR_WIDTH{1'b0}};
      sel_data_s = {DATA_WIDTH{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_addr_s = sel_addr_s | (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{grant_s[i]}});
         sel_data_s = sel_data_s | (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_s[i]}});
      end
   end

   assign addr_done_s = write_r ? ((!awvalid_r || m.awready) && (!wvalid_r || m.wready))
                                : (arvalid_r && m.arready);
   assign resp_fire_s = write_r ? (bready_r && m.bvalid) : (rready_r && m.rvalid);
   assign ret_fire_s  = |(rsp_valid_r & rsp_ready);

   // Next-state decode; req_ready is held low while reset is asserted
   always_comb begin
      state_nxt_s = state_r;
      req_ready   = {NUM_REQ{1'b0}};
      capture_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (found_s && rst) begin
               req_ready   = grant_s;
               capture_s   = 1'b1;
               state_nxt_s = ST_ADDR;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ADDR: begin
            if (addr_done_s) state_nxt_s = ST_RESP;
            else             state_nxt_s = ST_ADDR;
         end
         ST_RESP: begin
            if (resp_fire_s) state_nxt_s = ST_RETURN;
            else             state_nxt_s = ST_RESP;
         end
         ST_RETURN: begin
            if (ret_fire_s) state_nxt_s = ST_IDLE;
            else            state_nxt_s = ST_RETURN;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_r <= ST_IDLE;
      else      state_r <= state_nxt_s;
   end

   // Command capture, AXI channel valids/readies and response registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_r       <= IDX_W'(NUM_REQ - 1);
         gnt_idx_r   <= {IDX_W{1'b0}};
         write_r     <= 1'b0;
         addr_r      <= {ADDR_WIDTH{1'b0}};
         data_r      <= {DATA_WIDTH{1'b0}};
         awvalid_r   <= 1'b0;
         wvalid_r    <= 1'b0;
         arvalid_r   <= 1'b0;
         bready_r    <= 1'b0;
         rready_r    <= 1'b0;
         rsp_valid_r <= {NUM_REQ{1'b0}};
         rsp_data_r  <= {DATA_WIDTH{1'b0}};
         rsp_err_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (capture_s) begin
                  ptr_r     <= grant_idx_s;
                  gnt_idx_r <= grant_idx_s;
                  write_r   <= |(req_write & grant_s);
                  addr_r    <= sel_addr_s;
                  data_r    <= sel_data_s;
                  awvalid_r <= |(req_write & grant_s);
                  wvalid_r  <= |(req_write & grant_s);
                  arvalid_r <= ~|(req_write & grant_s);
               end
            end
            ST_ADDR: begin
               if (m.awready) awvalid_r <= 1'b0;
               if (m.wready)  wvalid_r  <= 1'b0;
               if (m.arready) arvalid_r <= 1'b0;
               if (addr_done_s) begin
                  bready_r <= write_r;
                  rready_r <= !write_r;
               end
            end
            ST_RESP: begin
               if (resp_fire_s) begin
                  bready_r    <= 1'b0;
                  rready_r    <= 1'b0;
                  rsp_data_r  <= write_r ? {DATA_WIDTH{1'b0}} : m.rdata;
                  rsp_err_r   <= resp_is_err(write_r ? m.bresp : m.rresp);
                  rsp_valid_r <= gnt_onehot_s;
               end
            end
            ST_RETURN: begin
               if (ret_fire_s) rsp_valid_r <= {NUM_REQ{1'b0}};
            end
            default: begin
               rsp_valid_r <= {NUM_REQ{1'b0}};
            end
         endcase
      end
   end

   assign rsp_valid = rsp_valid_r;
   assign rsp_data  = rsp_data_r;
   assign rsp_err   = rsp_err_r;

   assign m.awvalid = awvalid_r;
   assign m.awaddr  = addr_r;
   assign m.awprot  = PROT_DEFAULT;
   assign m.wvalid  = wvalid_r;
   assign m.wdata   = data_r;
   assign m.wstrb   = {(DATA_WIDTH/8){1'b1}};
   assign m.bready  = bready_r;
   assign m.arvalid = arvalid_r;
   assign m.araddr  = addr_r;
   assign m.arprot  = PROT_DEFAULT;
   assign m.rready  = rready_r;

endmodule

// File: tb/tb_rv_axi4_lite_req_arbiter.sv
// Directed bench for rv_axi4_lite_req_arbiter; the bench plays the AXI4-lite subordinate.
module tb_rv_axi4_lite_req_arbiter;
   import rv_axi4_lite_req_arbiter_pkg::*;

   localparam int NR = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    req_valid, req_ready, req_write, req_lock, rsp_valid, rsp_ready;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_data;
   logic [DW-1:0]    rsp_data;
   logic             rsp_err;
   logic [1:0]       exp_g;
   logic [1:0]       lock_exp [4];
   int               n0;
   int               checks = 0;
   int               errors = 0;

   rv_axi4_lite_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

   rv_axi4_lite_req_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_lock  (req_lock),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .m         (axi)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   initial begin
`ifdef RV_AXI_ARB_LOCK_EN
      lock_exp = '{2'b01, 2'b01, 2'b01, 2'b10};
`else
      lock_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
      rst = 1'b0; req_valid = 2'b00; req_write = 2'b00; req_lock = 2'b00; rsp_ready = 2'b00;
      req_addr = 64'h0; req_data = 64'h0;
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = RESP_OKAY;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'h0; axi.rresp = RESP_OKAY;
      step(); step();

      // reset state
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_awvalid", 32'(axi.awvalid), 32'h0);
      chk("rst_wvalid", 32'(axi.wvalid), 32'h0);
      chk("rst_arvalid", 32'(axi.arvalid), 32'h0);
      chk("rst_bready", 32'(axi.bready), 32'h0);
      chk("rst_rready", 32'(axi.rready), 32'h0);
      chk("rst_rsp_data", rsp_data, 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'h0);
      rst = 1'b1;
      step();

      // single zero-wait write from requester 0
      req_valid = 2'b01; req_write = 2'b01; req_addr[31:0] = 32'h4; req_data[31:0] = 32'hA5;
      axi.awready = 1'b1; axi.wready = 1'b1;
      #1 chk("wr_req_ready", 32'(req_ready), 32'h1);
      step();
      req_valid = 2'b00;
      chk("wr_awvalid", 32'(axi.awvalid), 32'h1);
      chk("wr_wvalid", 32'(axi.wvalid), 32'h1);
      chk("wr_awaddr", axi.awaddr, 32'h4);
      chk("wr_wdata", axi.wdata, 32'hA5);
      chk("wr_wstrb", 32'(axi.wstrb), 32'hF);
      chk("wr_awprot", 32'(axi.awprot), 32'h0);
      chk("wr_arvalid", 32'(axi.arvalid), 32'h0);
      step();
      chk("wr_awvalid_done", 32'(axi.awvalid), 32'h0);
      chk("wr_wvalid_done", 32'(axi.wvalid), 32'h0);
      chk("wr_bready", 32'(axi.bready), 32'h1);
      axi.bvalid = 1'b1; axi.bresp = RESP_OKAY;
      step();
      axi.bvalid = 1'b0;
      chk("wr_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("wr_rsp_err", 32'(rsp_err), 32'h0);
      chk("wr_rsp_data", rsp_data, 32'h0);
      chk("wr_bready_off", 32'(axi.bready), 32'h0);
      rsp_ready = 2'b01;
      step();
      chk("wr_rsp_released", 32'(rsp_valid), 32'h0);

      // read from requester 1 with ARREADY wait states and response backpressure
      rsp_ready = 2'b00; req_valid = 2'b10; req_write = 2'b00; req_addr[63:32] = 32'h8;
      axi.awready = 1'b0; axi.wready = 1'b0;
      #1 chk("rd_req_ready", 32'(req_ready), 32'h2);
      step();
      req_valid = 2'b00;
      chk("rd_arvalid", 32'(axi.arvalid), 32'h1);
      chk("rd_araddr", axi.araddr, 32'h8);
      chk("rd_awvalid", 32'(axi.awvalid), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rd_arvalid_wait", 32'(axi.arvalid), 32'h1);
      end
      axi.arready = 1'b1;
      step();
      axi.arready = 1'b0;
      chk("rd_arvalid_done", 32'(axi.arvalid), 32'h0);
      chk("rd_rready", 32'(axi.rready), 32'h1);
      axi.rvalid = 1'b1; axi.rdata = 32'h1234; axi.rresp = RESP_OKAY;
      step();
      axi.rvalid = 1'b0; axi.rdata = 32'hDEAD;
      chk("rd_rsp_valid", 32'(rsp_valid), 32'h2);
      chk("rd_rsp_data", rsp_data, 32'h1234);
      chk("rd_rsp_err", 32'(rsp_err), 32'h0);
      rsp_ready = 2'b01;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_rsp_valid", 32'(rsp_valid), 32'h2);
         chk("bp_rsp_data", rsp_data, 32'h1234);
      end
      rsp_ready = 2'b10;
      step();
      chk("rd_rsp_released", 32'(rsp_valid), 32'h0);

      // contention: both requesters hold valid, grants alternate
      req_addr = {32'h14, 32'h10}; req_data = {32'h22, 32'h11}; req_write = 2'b11;
      axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b1; axi.bresp = RESP_OKAY;
      rsp_ready = 2'b11; req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         #1 chk("cont_grant", 32'(req_ready), 32'(exp_g));
         step();
         chk("cont_awaddr", axi.awaddr, (k % 2 == 0) ? 32'h10 : 32'h14);
         step(); step();
         chk("cont_rsp_valid", 32'(rsp_valid), 32'(exp_g));
         step();
      end

      // DECERR read from requester 0
      req_valid = 2'b01; req_write = 2'b00; axi.bvalid = 1'b0;
      axi.arready = 1'b1; axi.rvalid = 1'b1; axi.rresp = RESP_DECERR; axi.rdata = 32'hBEEF;
      step();
      req_valid = 2'b00;
      step(); step();
      chk("decerr_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("decerr_rsp_err", 32'(rsp_err), 32'h1);
      chk("decerr_rsp_data", rsp_data, 32'hBEEF);
      step();
      axi.arready = 1'b0; axi.rvalid = 1'b0;

      // SLVERR write from requester 1
      req_valid = 2'b10; req_write = 2'b10; axi.bvalid = 1'b1; axi.bresp = RESP_SLVERR;
      step();
      req_valid = 2'b00;
      step(); step();
      chk("slverr_rsp_valid", 32'(rsp_valid), 32'h2);
      chk("slverr_rsp_err", 32'(rsp_err), 32'h1);
      chk("slverr_rsp_data", rsp_data, 32'h0);
      step();

      // lock: requester 0 issues two locked commands then an unlocked one
      axi.bresp = RESP_OKAY; req_write = 2'b11; req_valid = 2'b11; n0 = 0;
      for (int k = 0; k < 4; k++) begin
         req_lock = {1'b0, (n0 < 2)};
         #1 chk("lock_grant", 32'(req_ready), 32'(lock_exp[k]));
         if (lock_exp[k] == 2'b01) n0++;
         step(); step(); step();
         chk("lock_rsp_valid", 32'(rsp_valid), 32'(lock_exp[k]));
         step();
      end

      // async reset in ADDR, then requester 0 has first priority
      req_lock = 2'b00; req_valid = 2'b01; req_write = 2'b01;
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; rsp_ready = 2'b00;
      #1 chk("arst_grant0", 32'(req_ready), 32'h1);
      step();
      req_valid = 2'b11;
      chk("arst_awvalid_pre", 32'(axi.awvalid), 32'h1);
      #2 rst = 1'b0;
      #1;
      chk("arst_awvalid", 32'(axi.awvalid), 32'h0);
      chk("arst_wvalid", 32'(axi.wvalid), 32'h0);
      chk("arst_arvalid", 32'(axi.arvalid), 32'h0);
      chk("arst_bready", 32'(axi.bready), 32'h0);
      chk("arst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("arst_req_ready", 32'(req_ready), 32'h0);
      step();
      rst = 1'b1;
      #1 chk("arst_first_grant", 32'(req_ready), 32'h1);
      req_valid = 2'b00;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv_axi4_lite_req_arbiter.md
Name: rv_axi4_lite_req_arbiter

Overview:
Round-robin scheduler that shares one AXI4-lite register port (e.g. the I2C controller's control/status port) between NUM_REQ simple requesters. Each requester issues single register read/write commands. The block serialises them into AXI4-lite manager transactions with one outstanding transaction at a time, then returns the read data and error status to the originating requester.

Parameters:
NUM_REQ, 2, number of requester ports (>=2)
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width (multiple of 8)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester command valid
req_ready  out  NUM_REQ  per-requester command accept; one-hot or zero
req_write  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*ADDR_WIDTH  packed per-requester address, slice i = requester i
req_data  in  NUM_REQ*DATA_WIDTH  packed write data
req_lock  in  NUM_REQ  hold grant after this command (see Optional Feature)
rsp_valid  out  NUM_REQ  one-hot response valid
rsp_ready  in  NUM_REQ  response accept
rsp_data  out  DATA_WIDTH  read data (0 for writes), shared across requesters
rsp_err  out  1  1 when BRESP/RRESP != OKAY
m_aw*  out/in  AWVALID out, AWREADY in, AWADDR out ADDR_WIDTH, AWPROT out 3
m_w*  out/in  WVALID out, WREADY in, WDATA out DATA_WIDTH, WSTRB out DATA_WIDTH/8
m_b*  in/out  BVALID in, BREADY out, BRESP in 2
m_ar*  out/in  ARVALID out, ARREADY in, ARADDR out ADDR_WIDTH, ARPROT out 3
m_r*  in/out  RVALID in, RREADY out, RDATA in DATA_WIDTH, RRESP in 2

Behaviour:
- Reset (rst low, async): state IDLE; every valid/ready output 0; rsp_data 0; rsp_err 0; last-grant pointer = NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, ADDR, RESP, RETURN.
- IDLE:
  - Grantee g = first i with req_valid[i], searching from pointer+1 with wrap-around.
  - req_ready[g]=1 combinationally in the same cycle; command captured; pointer<=g; next state ADDR.
  - No valid requester: remain in IDLE.
- ADDR, write:
  - AWVALID and WVALID both asserted in the cycle after capture.
  - Each channel deasserts independently after its own handshake; both handshakes may occur in the same cycle.
  - Move to RESP when both channels are done.
- ADDR, read: ARVALID until ARREADY, then RESP.
- Constant outputs: WSTRB all ones; AWPROT/ARPROT 3'b000.
- RESP:
  - BREADY=1 (write) or RREADY=1 (read) for the whole state.
  - On handshake, capture rsp_data (RDATA, or 0 for a write) and rsp_err = (resp != OKAY); go to RETURN.
- RETURN:
  - rsp_valid[g]=1 and held, with stable data, until rsp_ready[g]. Then IDLE.
  - rsp_ready of non-granted requesters is ignored.
- Minimum turnaround: 4 cycles per command (accept, addr, resp, return) with zero-wait subordinate.
- Fairness:
  - A requester holding req_valid continuously is granted within NUM_REQ commands.
  - Simultaneous requests are resolved solely by the pointer.
- Requester must hold req_valid and payload stable until req_ready.
- Reset mid-transaction abandons the AXI transaction. The subordinate shares this reset domain.

Optional Feature:
Macro RV_AXI_ARB_LOCK_EN.
- Defined:
  - req_lock[g] is captured with the command.
  - If set, the pointer is frozen and IDLE grants only requester g; other requesters stall.
  - The lock clears after a command from g with req_lock=0 completes RETURN.
  - Enables atomic multi-register sequences such as configure-then-start on the I2C controller.
- Undefined: req_lock port present but ignored; pure round-robin.

Decomposition:
- Add the state enum (IDLE/ADDR/RESP/RETURN) to the shared rv_axi4_lite package. Reuse the package's existing resp/prot types and OKAY constant.
- Natural sub-module: rv_rr_arbiter (NUM_REQ request vector + pointer -> one-hot grant and index), combinational, reusable.

Test Plan:
- Single write: req0 write addr 0x04 data 0xA5 -> one AW/W with AWADDR 0x04, WDATA 0xA5, WSTRB 0xF; rsp_valid[0] with rsp_err 0, rsp_data 0.
- Read with wait states: req1 read 0x08, ARREADY delayed 3 cycles, RDATA 0x1234 -> rsp_valid[1], rsp_data 0x1234.
- Contention: req0 and req1 both valid continuously after reset -> grants alternate 0,1,0,1; no requester waits more than one command.
- Error: BRESP=SLVERR on a write -> rsp_err 1. RRESP=DECERR on a read -> rsp_err 1, rsp_data = RDATA.
- Lock (RV_AXI_ARB_LOCK_EN): req0 sends two locked commands then one unlocked while req1 is valid -> req1 granted only after req0's third response.
- Backpressure and async reset:
  - rsp_ready low 5 cycles -> rsp_valid and rsp_data held stable.
  - rst low during ADDR -> all valids 0 immediately; after release, requester 0 is granted first.
